// File: rtl/change_dispenser.sv
`default_nettype none
// ============================================================================
// Module   : change_dispenser
// Purpose  : Pays a change amount out as 25/10/5 coin-eject handshakes,
//            greedy largest-first, tracking per-denomination inventory.
// Revision : 1.0 - initial release
// ============================================================================
module change_dispenser #(
    parameter int         W        = 8,
    parameter int         VAL_L    = 25,
    parameter int         VAL_M    = 10,
    parameter int         VAL_S    = 5,
    parameter logic [7:0] INIT_CNT = 8'd20
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] amount,
    input  logic         restock,
    input  logic         hopper_ready,
    output logic [2:0]   eject_req,
    output logic         busy,
    output logic         done,
    output logic         short,
    output logic [W-1:0] residue,
    output logic [2:0]   empty
);

    localparam logic [W-1:0] c_val_l = W'(VAL_L);
    localparam logic [W-1:0] c_val_m = W'(VAL_M);
    localparam logic [W-1:0] c_val_s = W'(VAL_S);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SELECT = 2'd1,
        S_EJECT  = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t         r_state, w_state;
    logic [W-1:0]   r_remaining, w_remaining;
    logic [7:0]     r_cnt_l, r_cnt_m, r_cnt_s;
    logic [7:0]     w_cnt_l, w_cnt_m, w_cnt_s;
    logic [2:0]     r_eject, w_eject;
    logic           r_busy, w_busy;
    logic           r_done, w_done;
    logic           r_short, w_short;
    logic [W-1:0]   r_residue, w_residue;
    logic [2:0]     r_empty, w_empty;

    always_comb begin
        w_state     = r_state;
        w_remaining = r_remaining;
        w_cnt_l     = r_cnt_l;
        w_cnt_m     = r_cnt_m;
        w_cnt_s     = r_cnt_s;
        w_eject     = r_eject;
        w_busy      = r_busy;
        w_done      = 1'b0;
        w_short     = r_short;
        w_residue   = r_residue;

        case (r_state)
            S_IDLE: begin
                // Restock lands on the same edge as load, so the payout sees full counts
                if (restock) begin
                    w_cnt_l = INIT_CNT;
                    w_cnt_m = INIT_CNT;
                    w_cnt_s = INIT_CNT;
                end
                if (load) begin
                    w_remaining = amount;
                    w_busy      = 1'b1;
                    w_short     = 1'b0;
                    w_residue   = '0;
                    w_state     = S_SELECT;
                end
            end
            S_SELECT: begin
                if (r_remaining == '0) begin
                    w_done    = 1'b1;
                    w_short   = 1'b0;
                    w_residue = '0;
                    w_state   = S_DONE;
                end else if (r_remaining >= c_val_l && r_cnt_l != 8'd0) begin
                    w_eject = 3'b100;
                    w_state = S_EJECT;
                end else if (r_remaining >= c_val_m && r_cnt_m != 8'd0) begin
                    w_eject = 3'b010;
                    w_state = S_EJECT;
                end else if (r_remaining >= c_val_s && r_cnt_s != 8'd0) begin
                    w_eject = 3'b001;
                    w_state = S_EJECT;
                end else begin
                    w_done    = 1'b1;
                    w_short   = 1'b1;
                    w_residue = r_remaining;
                    w_state   = S_DONE;
                end
            end
            S_EJECT: begin
                if (hopper_ready) begin
                    case (r_eject)
                        3'b100: begin
                            w_remaining = r_remaining - c_val_l;
                            w_cnt_l     = (r_cnt_l != 8'd0) ? r_cnt_l - 8'd1 : 8'd0;
                        end
                        3'b010: begin
                            w_remaining = r_remaining - c_val_m;
                            w_cnt_m     = (r_cnt_m != 8'd0) ? r_cnt_m - 8'd1 : 8'd0;
                        end
                        3'b001: begin
                            w_remaining = r_remaining - c_val_s;
                            w_cnt_s     = (r_cnt_s != 8'd0) ? r_cnt_s - 8'd1 : 8'd0;
                        end
                        default: w_remaining = r_remaining;
                    endcase
                    w_eject = 3'b000;
                    w_state = S_SELECT;
                end
            end
            S_DONE: begin
                w_busy  = 1'b0;
                w_state = S_IDLE;
            end
            default: w_state = S_IDLE;
        endcase

        // Flags track the counts being written this edge, keeping them in step
        w_empty = {w_cnt_l == 8'd0, w_cnt_m == 8'd0, w_cnt_s == 8'd0};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_remaining <= '0;
            r_cnt_l     <= INIT_CNT;
            r_cnt_m     <= INIT_CNT;
            r_cnt_s     <= INIT_CNT;
            r_eject     <= 3'b000;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_short     <= 1'b0;
            r_residue   <= '0;
            r_empty     <= {3{INIT_CNT == 8'd0}};
        end else begin
            r_state     <= w_state;
            r_remaining <= w_remaining;
            r_cnt_l     <= w_cnt_l;
            r_cnt_m     <= w_cnt_m;
            r_cnt_s     <= w_cnt_s;
            r_eject     <= w_eject;
            r_busy      <= w_busy;
            r_done      <= w_done;
            r_short     <= w_short;
            r_residue   <= w_residue;
            r_empty     <= w_empty;
        end
    end

    assign eject_req = r_eject;
    assign busy      = r_busy;
    assign done      = r_done;
    assign short     = r_short;
    assign residue   = r_residue;
    assign empty     = r_empty;

endmodule
`default_nettype wire
